// File: rtl/cache_controller_dm_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache controller.
package cache_controller_dm_pkg;

  localparam int unsigned OFFSET_BITS   = 6;
  localparam int unsigned WORD_SEL_BITS = 4;
  localparam int unsigned LINE_BITS     = 512;

  typedef logic [LINE_BITS-1:0] line_t;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWbStart,
    StWbWait,
    StRfStart,
    StRfWait,
    StRefillWr,
    StResp
  } cache_state_t;

  function automatic int unsigned tag_bits(input int unsigned addr_bits,
                                           input int unsigned index_bits);
    return addr_bits - OFFSET_BITS - index_bits;
  endfunction

endpackage

// File: rtl/cache_controller_dm_if.sv
// CPU load/store port plus miss-handler port; master is the CPU/miss-handler side.
interface cache_controller_dm_if #(
  parameter int unsigned LINE_SIZE = 512,
  parameter int unsigned ADDR_BITS = 27
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADDR_BITS-1:0] req_addr;
  logic [31:0]          req_wdata;
  logic [3:0]           req_wstrb;
  logic                 resp_valid;
  logic [31:0]          resp_rdata;
  logic [ADDR_BITS-1:0] mh_addr;
  logic [LINE_SIZE-1:0] mh_din;
  logic                 mh_start;
  logic                 mh_mode;
  logic [LINE_SIZE-1:0] mh_dout;
  logic                 mh_complete;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, mh_dout, mh_complete,
    input  req_ready, resp_valid, resp_rdata, mh_addr, mh_din, mh_start, mh_mode
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, mh_dout, mh_complete,
    output req_ready, resp_valid, resp_rdata, mh_addr, mh_din, mh_start, mh_mode
  );
endinterface

// File: rtl/cache_controller_dm_line_ram.sv
// Single-port line RAM: synchronous read, per-byte write enable across the whole line.
module cache_controller_dm_line_ram #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned LINE_SIZE  = 512
) (
  input  logic                   clk,
  input  logic [INDEX_BITS-1:0]  addr,
  input  logic [LINE_SIZE/8-1:0] be,
  input  logic [LINE_SIZE-1:0]   wdata,
  output logic [LINE_SIZE-1:0]   rdata
);

  logic [LINE_SIZE-1:0] mem [2**INDEX_BITS];

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < LINE_SIZE / 8; b++) begin
      if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/cache_controller_dm.sv
// Direct-mapped, write-back, write-allocate data cache; misses go through the miss handler
// as an optional writeback followed by a refill.
module cache_controller_dm
  import cache_controller_dm_pkg::*;
#(
  parameter int unsigned LINE_SIZE  = 512,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned ADDR_BITS  = 27
) (
  input  logic                 clk,
  input  logic                 rstn,
  cache_controller_dm_if.slave bus
);

  localparam int unsigned TagBits  = tag_bits(ADDR_BITS, INDEX_BITS);
  localparam int unsigned NumLines = 2 ** INDEX_BITS;
  localparam int unsigned BeBits   = LINE_SIZE / 8;

  cache_state_t state_q, state_d;

  logic                     init_q, we_q, mh_mode_q;
  logic [ADDR_BITS-1:0]     addr_q, mh_addr_q;
  logic [31:0]              wdata_q, resp_rdata_q;
  logic [3:0]               wstrb_q;
  logic [LINE_SIZE-1:0]     line_q, ram_rdata, ram_wdata, refill_line;
  logic [BeBits-1:0]        ram_be, store_be;
  logic [INDEX_BITS-1:0]    idx, ram_addr;
  logic [TagBits-1:0]       req_tag;
  logic [WORD_SEL_BITS-1:0] word;
  logic [TagBits-1:0]       tag_q [NumLines];
  logic [NumLines-1:0]      valid_q, dirty_q;
  logic                     req_ready, accept, hit, victim_dirty;
  logic                     unused_addr;

  assign idx          = addr_q[OFFSET_BITS +: INDEX_BITS];
  assign req_tag      = addr_q[ADDR_BITS-1 -: TagBits];
  assign word         = addr_q[2 +: WORD_SEL_BITS];
  assign unused_addr  = ^addr_q[1:0];
  assign hit          = valid_q[idx] && (tag_q[idx] == req_tag);
  assign victim_dirty = valid_q[idx] && dirty_q[idx];
  assign req_ready    = (state_q == StIdle) && !init_q;
  assign accept       = bus.req_valid && req_ready;
  // In IDLE the RAM read is launched straight from the request so LOOKUP sees the line.
  assign ram_addr     = (state_q == StIdle) ? bus.req_addr[OFFSET_BITS +: INDEX_BITS] : idx;

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mh_start   = (state_q == StWbStart) || (state_q == StRfStart);
  assign bus.mh_mode    = mh_mode_q;
  assign bus.mh_addr    = mh_addr_q;
  assign bus.mh_din     = line_q;

  always_comb begin
    refill_line = line_q;
    store_be    = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      if (wstrb_q[b]) begin
        store_be[{word, 2'(b)}] = 1'b1;
        if (we_q) refill_line[{word, 2'(b), 3'b000} +: 8] = wdata_q[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ram_be    = '0;
    ram_wdata = refill_line;
    unique case (state_q)
      StIdle:    if (accept) state_d = StLookup;
      StLookup: begin
        if (hit) begin
          if (we_q) begin
            ram_be    = store_be;
            ram_wdata = {(LINE_SIZE / 32){wdata_q}};
          end
          state_d = StResp;
        end else begin
          state_d = victim_dirty ? StWbStart : StRfStart;
        end
      end
      StWbStart: state_d = StWbWait;
      StWbWait:  if (bus.mh_complete) state_d = StRfStart;
      StRfStart: state_d = StRfWait;
      StRfWait:  if (bus.mh_complete) state_d = StRefillWr;
      StRefillWr: begin
        ram_be  = '1;
        state_d = StResp;
      end
      StResp:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= StIdle;
      init_q       <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      line_q       <= '0;
      resp_rdata_q <= '0;
      mh_addr_q    <= '0;
      mh_mode_q    <= 1'b0;
      valid_q      <= '0;
      dirty_q      <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            wstrb_q <= bus.req_wstrb;
          end
        end
        StLookup: begin
          if (hit) begin
            if (we_q) dirty_q[idx] <= 1'b1;
            else      resp_rdata_q <= ram_rdata[{word, 5'b00000} +: 32];
          end else begin
            line_q    <= ram_rdata;
            mh_mode_q <= victim_dirty;
            mh_addr_q <= victim_dirty ? {tag_q[idx], idx, {OFFSET_BITS{1'b0}}}
                                      : {req_tag, idx, {OFFSET_BITS{1'b0}}};
          end
        end
        StWbWait: begin
          if (bus.mh_complete) begin
            mh_mode_q <= 1'b0;
            mh_addr_q <= {req_tag, idx, {OFFSET_BITS{1'b0}}};
          end
        end
        StRfWait:  if (bus.mh_complete) line_q <= bus.mh_dout;
        StRefillWr: begin
          valid_q[idx] <= 1'b1;
          dirty_q[idx] <= we_q;
          if (!we_q) resp_rdata_q <= line_q[{word, 5'b00000} +: 32];
        end
        default: ;
      endcase
    end
  end

  // Tags need no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (rstn && (state_q == StRefillWr)) tag_q[idx] <= req_tag;
  end

  cache_controller_dm_line_ram #(
    .INDEX_BITS(INDEX_BITS),
    .LINE_SIZE (LINE_SIZE)
  ) u_line_ram (
    .clk  (clk),
    .addr (ram_addr),
    .be   (ram_be),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_cache_controller_dm.sv
// Directed bench for cache_controller_dm with a behavioural miss handler (completes ~10 cycles
// after start, refill data is a fixed pattern of the line address).
module tb_cache_controller_dm;
  import cache_controller_dm_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  cache_controller_dm_if bus ();

  cache_controller_dm dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Refill word i of line a = {A0+i, a[23:0]}.
  function automatic line_t pattern(input logic [26:0] a);
    line_t p;
    for (int i = 0; i < 16; i++) p[32*i +: 32] = {8'(32'hA0 + i), a[23:0]};
    return p;
  endfunction

  // Miss handler model and log of every start it sees.
  int          n_start    = 0;
  int          violations = 0;
  logic        busy;
  int          cnt;
  logic [26:0] cur_addr;
  logic        cur_mode;
  logic [26:0] log_addr [16];
  logic        log_mode [16];
  logic [31:0] log_w0   [16];
  logic [31:0] log_w1   [16];
  logic [31:0] log_w2   [16];

  always @(posedge clk) begin
    if (!rstn) begin
      busy            <= 1'b0;
      cnt             <= 0;
      bus.mh_complete <= 1'b0;
      bus.mh_dout     <= '0;
    end else begin
      bus.mh_complete <= 1'b0;
      if (busy) begin
        if (bus.mh_start) violations <= violations + 1;
        if (bus.mh_mode !== cur_mode || bus.mh_addr !== cur_addr) violations <= violations + 1;
        if (cnt == 9) begin
          busy            <= 1'b0;
          bus.mh_complete <= 1'b1;
          bus.mh_dout     <= pattern(cur_addr);
        end
        cnt <= cnt + 1;
      end else if (bus.mh_start) begin
        busy                 <= 1'b1;
        cnt                  <= 0;
        cur_addr             <= bus.mh_addr;
        cur_mode             <= bus.mh_mode;
        log_addr[n_start%16] <= bus.mh_addr;
        log_mode[n_start%16] <= bus.mh_mode;
        log_w0[n_start%16]   <= bus.mh_din[31:0];
        log_w1[n_start%16]   <= bus.mh_din[63:32];
        log_w2[n_start%16]   <= bus.mh_din[95:64];
        n_start              <= n_start + 1;
      end
    end
  end

  task automatic cpu_req(input logic we, input logic [26:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, output logic [31:0] rd, output int lat);
    int   k;
    logic got;
    rd  = '0;
    lat = 0;
    got = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_wstrb = ws;
    k = 0;
    while (!bus.req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = c;
        rd  = bus.resp_rdata;
        got = 1'b1;
        break;
      end
    end
    check_eq("resp_seen", 64'(got), 64'd1);
    @(negedge clk);
    check_eq("resp_pulse", 64'(bus.resp_valid), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 64'(bus.req_ready), 64'd0);
    check_eq({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    check_eq({tag, "_resp_rdata"}, 64'(bus.resp_rdata), 64'd0);
    check_eq({tag, "_mh_start"}, 64'(bus.mh_start), 64'd0);
    check_eq({tag, "_mh_mode"}, 64'(bus.mh_mode), 64'd0);
    check_eq({tag, "_mh_addr"}, 64'(bus.mh_addr), 64'd0);
    check_eq({tag, "_mh_din"}, 64'(|bus.mh_din), 64'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    int          base;
    logic        seen;

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    #1;
    check_eq("ready_first_cycle", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    check_eq("ready_after", 64'(bus.req_ready), 64'd1);

    // Cold load: refill only.
    base = n_start;
    cpu_req(1'b0, 27'h0000100, '0, '0, rd, lat);
    check_eq("cold_starts", 64'(n_start - base), 64'd1);
    check_eq("cold_mode", 64'(log_mode[base%16]), 64'd0);
    check_eq("cold_addr", 64'(log_addr[base%16]), 64'h100);
    check_eq("cold_rdata", 64'(rd), 64'hA0000100);

    // Hit load.
    base = n_start;
    cpu_req(1'b0, 27'h0000104, '0, '0, rd, lat);
    check_eq("hit_starts", 64'(n_start - base), 64'd0);
    check_eq("hit_latency", 64'(lat), 64'd2);
    check_eq("hit_rdata", 64'(rd), 64'hA1000100);

    // Partial store hit, then read it back.
    base = n_start;
    cpu_req(1'b1, 27'h0000108, 32'hDEADBEEF, 4'b0011, rd, lat);
    check_eq("st_hit_latency", 64'(lat), 64'd2);
    check_eq("st_hit_rdata_hold", 64'(rd), 64'hA1000100);
    cpu_req(1'b0, 27'h0000108, '0, '0, rd, lat);
    check_eq("st_hit_readback", 64'(rd), 64'hA200BEEF);
    check_eq("st_hit_starts", 64'(n_start - base), 64'd0);
    check_eq("st_hit_dirty", 64'(dut.dirty_q[4]), 64'd1);

    // Conflict miss on the dirty line: writeback then refill.
    base = n_start;
    cpu_req(1'b0, 27'h0001100, '0, '0, rd, lat);
    check_eq("evict_starts", 64'(n_start - base), 64'd2);
    check_eq("evict_wb_mode", 64'(log_mode[base%16]), 64'd1);
    check_eq("evict_wb_addr", 64'(log_addr[base%16]), 64'h100);
    check_eq("evict_wb_w0", 64'(log_w0[base%16]), 64'hA0000100);
    check_eq("evict_wb_w2", 64'(log_w2[base%16]), 64'hA200BEEF);
    check_eq("evict_rf_mode", 64'(log_mode[(base+1)%16]), 64'd0);
    check_eq("evict_rf_addr", 64'(log_addr[(base+1)%16]), 64'h1100);
    check_eq("evict_rdata", 64'(rd), 64'hA0001100);

    // Store miss to an invalid line: refill only, merged, dirty.
    base = n_start;
    cpu_req(1'b1, 27'h0000204, 32'h12345678, 4'b1100, rd, lat);
    check_eq("st_miss_starts", 64'(n_start - base), 64'd1);
    check_eq("st_miss_mode", 64'(log_mode[base%16]), 64'd0);
    check_eq("st_miss_addr", 64'(log_addr[base%16]), 64'h200);
    check_eq("st_miss_dirty", 64'(dut.dirty_q[8]), 64'd1);
    base = n_start;
    cpu_req(1'b0, 27'h0000204, '0, '0, rd, lat);
    check_eq("st_miss_readback", 64'(rd), 64'h12340200);
    check_eq("st_miss_rb_latency", 64'(lat), 64'd2);
    check_eq("st_miss_rb_starts", 64'(n_start - base), 64'd0);

    // Evicting that line writes back the merged data.
    base = n_start;
    cpu_req(1'b0, 27'h0001200, '0, '0, rd, lat);
    check_eq("evict2_starts", 64'(n_start - base), 64'd2);
    check_eq("evict2_wb_mode", 64'(log_mode[base%16]), 64'd1);
    check_eq("evict2_wb_addr", 64'(log_addr[base%16]), 64'h200);
    check_eq("evict2_wb_w0", 64'(log_w0[base%16]), 64'hA0000200);
    check_eq("evict2_wb_w1", 64'(log_w1[base%16]), 64'h12340200);
    check_eq("evict2_rf_addr", 64'(log_addr[(base+1)%16]), 64'h1200);
    check_eq("evict2_rdata", 64'(rd), 64'hA0001200);

    // Reset while waiting for a refill.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 27'h0000300;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.mh_start) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("abort_start_seen", 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    rstn = 1'b1;
    base = n_start;
    cpu_req(1'b0, 27'h0000300, '0, '0, rd, lat);
    check_eq("abort_reload_starts", 64'(n_start - base), 64'd1);
    check_eq("abort_reload_mode", 64'(log_mode[base%16]), 64'd0);
    check_eq("abort_reload_rdata", 64'(rd), 64'hA0000300);

    // Line 4 was invalidated by the reset, so this misses again without writeback.
    base = n_start;
    cpu_req(1'b0, 27'h0001104, '0, '0, rd, lat);
    check_eq("post_reset_starts", 64'(n_start - base), 64'd1);
    check_eq("post_reset_rdata", 64'(rd), 64'hA1001100);

    check_eq("mh_protocol", 64'(violations), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
